// File: rtl/aww_types_pkg.sv
// ============================================================================
// aww_types_pkg : instruction-cache geometry, frame layout and FSM states
// Revision      : 1.0
// ============================================================================
`default_nettype none

package aww_types_pkg;

  localparam int ICACHE_SETS = 16;
  localparam int IIDX_W      = 4;
  localparam int ITAG_W      = 26;

  typedef struct packed {
    logic                valid;
    logic [ITAG_W-1:0]   tag;
    cpu_types_pkg::word_t data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // Byte address layout: tag[31:6], index[5:2], byte offset[1:0].
  function automatic logic [IIDX_W-1:0] addr_index(input cpu_types_pkg::word_t addr);
    return addr[5:2];
  endfunction

  function automatic logic [ITAG_W-1:0] addr_tag(input cpu_types_pkg::word_t addr);
    return addr[31:6];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : basic datapath word type shared across the CPU
// Revision      : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

`default_nettype wire

// File: rtl/icache_if.sv
// ============================================================================
// icache_if : datapath-side and memory-side signals of the instruction cache
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface icache_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  // Cache view.
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // Datapath plus memory view.
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// icache : direct-mapped 16-frame instruction cache, one word per frame
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache
  import cpu_types_pkg::*;
  import aww_types_pkg::*;
(
  input  wire logic CLK,
  input  wire logic nRST,
  icache_if.slave   cif
);

  icache_frame_t       r_frames [ICACHE_SETS];
  icache_state_t       r_state;
  word_t               r_miss_addr;
  word_t               r_iaddr;
  logic                r_iren;

  logic [IIDX_W-1:0]   w_idx;
  logic [ITAG_W-1:0]   w_tag;
  icache_frame_t       w_frame;
  logic                w_hit;
  logic                w_fill;
  logic [IIDX_W-1:0]   w_miss_idx;
  logic [ITAG_W-1:0]   w_miss_tag;
  logic                w_unused;

  assign w_idx      = addr_index(cif.imemaddr);
  assign w_tag      = addr_tag(cif.imemaddr);
  assign w_frame    = r_frames[w_idx];
  assign w_hit      = (r_state == IDLE) && cif.imemREN && w_frame.valid && (w_frame.tag == w_tag);
  assign w_fill     = (r_state == FETCH) && !cif.iwait;
  assign w_miss_idx = addr_index(r_miss_addr);
  assign w_miss_tag = addr_tag(r_miss_addr);
  assign w_unused   = ^{cif.imemaddr[1:0], r_miss_addr[1:0]};

  // Hit path is purely combinational so a resident word returns the same cycle.
  assign cif.ihit     = w_hit;
  assign cif.imemload = w_frame.data;
  assign cif.iREN     = r_iren;
  assign cif.iaddr    = r_iaddr;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= '0;
      r_iaddr     <= '0;
      r_iren      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cif.imemREN && !w_hit) begin
            r_miss_addr <= {cif.imemaddr[31:2], 2'b00};
            r_iaddr     <= {cif.imemaddr[31:2], 2'b00};
            r_iren      <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          // A fetch always runs to completion even if the datapath drops its request.
          if (!cif.iwait) begin
            r_iaddr <= '0;
            r_iren  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_iaddr <= '0;
          r_iren  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Tags and data are cleared too so imemload never shows unknown content.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ICACHE_SETS; i++) begin
        r_frames[i] <= '0;
      end
    end else if (w_fill) begin
      r_frames[w_miss_idx] <= '{valid: 1'b1, tag: w_miss_tag, data: cif.iload};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// tb_icache : scoreboard bench for icache with an in-bench memory responder
// Revision  : 1.0
// ============================================================================
`default_nettype none

module tb_icache;
  import cpu_types_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  icache_if bus();

  icache dut (
    .CLK  (clk),
    .nRST (nrst),
    .cif  (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  word_t sb_q[$];

  task automatic check_eq(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory contents: the cold-read word at 0x40 is fixed, the rest are address-derived.
  function automatic word_t mem_word(input word_t a);
    word_t w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0040) return 32'h3C01_0004;
    return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
  endfunction

  task automatic sb_pop_check(input string tag);
    word_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%08h expected scoreboard entry (queue empty)", tag, bus.imemload);
    end else begin
      e = sb_q.pop_front();
      check_eq(tag, bus.imemload, e);
    end
  endtask

  // One datapath read; on a miss, the memory side answers after `waits` busy cycles.
  task automatic do_read(input word_t addr, input bit exp_hit, input int waits,
                         input word_t alt_addr, input bit drop_ren);
    @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    sb_q.push_back(mem_word(addr));
    #1;
    check_eq("ihit_first", word_t'(bus.ihit), word_t'(exp_hit));
    check_eq("iren_idle", word_t'(bus.iREN), 32'd0);
    if (exp_hit) begin
      sb_pop_check("hit_data");
      return;
    end
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      bus.imemaddr = alt_addr;
      bus.imemREN  = !drop_ren;
      bus.iwait    = (k < waits);
      bus.iload    = (k < waits) ? 32'hDEAD_BEEF : mem_word(addr);
      #1;
      check_eq("fetch_iren", word_t'(bus.iREN), 32'd1);
      check_eq("fetch_iaddr", bus.iaddr, {addr[31:2], 2'b00});
      check_eq("fetch_ihit", word_t'(bus.ihit), 32'd0);
    end
    @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    #1;
    check_eq("fill_ihit", word_t'(bus.ihit), 32'd1);
    check_eq("fill_iren", word_t'(bus.iREN), 32'd0);
    check_eq("fill_iaddr", bus.iaddr, 32'd0);
    sb_pop_check("fill_data");
  endtask

  initial begin
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    nrst         = 1'b0;

    repeat (3) @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    #1;
    check_eq("rst_ihit", word_t'(bus.ihit), 32'd0);
    check_eq("rst_iren", word_t'(bus.iREN), 32'd0);
    check_eq("rst_iaddr", bus.iaddr, 32'd0);
    @(negedge clk);
    bus.imemREN = 1'b0;
    nrst        = 1'b1;

    // Cold miss, warm hit, unaligned hit on the same word.
    do_read(32'h0000_0040, 1'b0, 3, 32'h0000_0040, 1'b0);
    do_read(32'h0000_0040, 1'b1, 0, 32'h0000_0040, 1'b0);
    do_read(32'h0000_0043, 1'b1, 0, 32'h0000_0043, 1'b0);

    // No request: no hit, no fetch.
    @(negedge clk);
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0040;
    #1;
    check_eq("noreq_ihit", word_t'(bus.ihit), 32'd0);
    check_eq("noreq_iren", word_t'(bus.iREN), 32'd0);
    @(negedge clk);
    #1;
    check_eq("noreq_iren2", word_t'(bus.iREN), 32'd0);

    // Conflict eviction on index 0.
    do_read(32'h0000_0080, 1'b0, 1, 32'h0000_0080, 1'b0);
    do_read(32'h0000_0040, 1'b0, 0, 32'h0000_0040, 1'b0);

    // Address changes mid-fetch; the original line must be the one filled.
    do_read(32'h0000_0010, 1'b0, 2, 32'h0000_0200, 1'b0);
    do_read(32'h0000_0010, 1'b1, 0, 32'h0000_0010, 1'b0);
    do_read(32'h0000_0200, 1'b0, 0, 32'h0000_0200, 1'b0);
    do_read(32'h0000_0010, 1'b1, 0, 32'h0000_0010, 1'b0);

    // Request dropped mid-fetch still completes the fill.
    do_read(32'h0000_0030, 1'b0, 2, 32'h0000_0030, 1'b1);

    // Reset in the middle of a fetch.
    @(negedge clk);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0020;
    bus.iwait    = 1'b1;
    #1;
    check_eq("rstf_ihit", word_t'(bus.ihit), 32'd0);
    @(negedge clk);
    #1;
    check_eq("rstf_iren_pre", word_t'(bus.iREN), 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rstf_iren", word_t'(bus.iREN), 32'd0);
    check_eq("rstf_iaddr", bus.iaddr, 32'd0);
    bus.imemREN = 1'b0;
    nrst        = 1'b1;
    do_read(32'h0000_0020, 1'b0, 1, 32'h0000_0020, 1'b0);
    do_read(32'h0000_0010, 1'b0, 0, 32'h0000_0010, 1'b0);

    // Fill every frame, then hit every frame.
    for (int i = 0; i < 16; i++) begin
      do_read(32'h0000_1000 + 32'(i * 4), 1'b0, i % 3, 32'h0000_1000 + 32'(i * 4), 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(32'h0000_1000 + 32'(i * 4), 1'b1, 0, 32'h0000_1000 + 32'(i * 4), 1'b0);
    end

    @(negedge clk);
    bus.imemREN = 1'b0;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
